// File: rtl/mux_pkg.sv
// Shared constants for the N:1 round-robin / forced-select multiplexer.
package mux_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_SEL = 1'b1;

endpackage

// File: rtl/mux_n_1_rr_arbiter.sv
// Round-robin search: starting after 'last', grant the first requesting channel.
module rr_arbiter #(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          grant_any
);

  // Scan last+1 .. last+N (mod N); the first requester found wins.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!grant_any && req[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_1_rr.sv
// N:1 valid/ready multiplexer with round-robin or forced channel selection
// and a single output register (1-cycle latency, full throughput).
module mux_n_1_rr
  import mux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 3,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  logic [SW-1:0] last;
  logic [N-1:0]  rr_grant;
  logic [SW-1:0] rr_idx;
  logic          rr_any;
  logic [N-1:0]  f_grant;
  logic          f_any;
  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          grant_any;
  logic [W-1:0]  grant_data;
  logic          load_en;
  logic          xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .last      (last),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

  // Forced select: matching by channel index makes sel >= N grant nothing.
  always_comb begin
    f_grant = '0;
    f_any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SW'(i) && in_valid[i]) begin
        f_grant[i] = 1'b1;
        f_any      = 1'b1;
      end
    end
  end

  // Pick the active grant source and mux out the granted channel's data.
  always_comb begin
    if (mode == MODE_SEL) begin
      grant     = f_grant;
      grant_idx = sel;
      grant_any = f_any;
    end else begin
      grant     = rr_grant;
      grant_idx = rr_idx;
      grant_any = rr_any;
    end
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) grant_data = in_data[i*W +: W];
    end
  end

  // Register may load when empty or being drained this cycle; no accepts in reset.
  always_comb begin
    load_en  = !out_valid || out_ready;
    in_ready = (load_en && !rst) ? grant : '0;
    xfer     = load_en && grant_any;
  end

  // Output register and round-robin pointer (pointer moves only on RR transfers).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= SW'(N - 1);
    end else if (load_en) begin
      out_valid <= grant_any;
      if (grant_any) begin
        out_data <= grant_data;
        out_ch   <= grant_idx;
      end
      if (xfer && mode == MODE_RR) last <= grant_idx;
    end
  end

endmodule

// File: doc/mux_n_1_rr.md
MUX_N_1_RR -- requirements
Module: mux_n_1_rr

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter W, default 3, giving the data width per channel.
REQ-003 The block SHALL have derived parameter SW = clog2(N), the channel-index width.
REQ-004 Port clk SHALL be an input of width 1: the single clock, rising edge.
REQ-005 Port rst SHALL be an input of width 1: reset, asynchronous and active-high.
REQ-006 Port in_valid SHALL be an input of width N: per-channel valid.
REQ-007 Port in_data SHALL be an input of width N*W: channel i occupies bits [i*W +: W].
REQ-008 Port in_ready SHALL be an output of width N: per-channel accept.
REQ-009 Port mode SHALL be an input of width 1: 0 = round-robin, 1 = forced select.
REQ-010 Port sel SHALL be an input of width SW: the forced-select channel index.
REQ-011 Port out_valid SHALL be an output of width 1: output register holds data.
REQ-012 Port out_data SHALL be an output of width W: the selected data.
REQ-013 Port out_ch SHALL be an output of width SW: the source channel of out_data.
REQ-014 Port out_ready SHALL be an input of width 1: downstream accept.

Function
REQ-015 A transfer on any port SHALL occur on a rising clk edge where valid and ready are both 1.
REQ-016 The output register SHALL load (load_en) when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-017 At most one in_ready bit SHALL be 1 per cycle; in_ready[g] = load_en AND grant[g], combinational, with no dependence on in_valid of other channels beyond arbitration.
REQ-018 Latency SHALL be 1 cycle: data accepted on edge k appears on out_data/out_ch with out_valid=1 after edge k; sustained throughput is 1 word/cycle when out_ready=1.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold stable and all in_ready SHALL be 0.
REQ-020 Round-robin mode (mode=0): the arbiter SHALL search channels last+1, last+2, ... (mod N) and grant the first with in_valid=1; last is updated to the granted index only on an actual transfer.
REQ-021 Forced mode (mode=1): the block SHALL grant channel sel if sel<N and in_valid[sel]=1, otherwise nothing; last is not updated.
REQ-022 For sel>=N (N not a power of two), no grant SHALL occur and out_valid SHALL only drain.
REQ-023 If no in_valid is set and the output drains, out_valid SHALL go 0 on the next edge; out_data and out_ch then hold their last values.
REQ-024 A mode or sel change SHALL affect only the next arbitration, never a word already held in the output register.
REQ-025 Wrap-around: with last=N-1, the search SHALL start at channel 0.

Reset
REQ-026 While rst=1: out_valid=0, out_data=0, out_ch=0, last=N-1, and all in_ready=0, regardless of clk.
REQ-027 A reset mid-transfer SHALL discard the held word; the first grant after reset release in round-robin mode SHALL go to the lowest-indexed valid channel.

Structure
REQ-028 Package mux_pkg SHALL hold the constants MODE_RR=1'b0 and MODE_SEL=1'b1.
REQ-029 Round-robin search SHALL be the sub-module rr_arbiter (inputs: req[N], last[SW]; output: one-hot grant[N] plus its index); the output register and forced-select logic SHALL reside in mux_n_1_rr.

Verification
REQ-030 N=8, W=3, mode=0, all in_valid=1, in_data[i]=i, out_ready=1 -> out_ch sequence 0,1,...,7,0 on consecutive cycles, with out_data=out_ch.
REQ-031 mode=0, in_valid=8'b1000_0100, last=2 after a ch2 grant -> the next grant is ch7, then ch2.
REQ-032 Ch3 valid with data 5, out_ready held 0 for 4 cycles -> out_valid=1, out_data=5, out_ch=3 stable, in_ready=0; ch3 accepts again only after out_ready=1.
REQ-033 mode=1, sel=6, in_valid=8'hFF -> only ch6 is granted each cycle; sel=6 with in_valid[6]=0 -> out_valid falls to 0 after the drain.
REQ-034 N=5, mode=1, sel=7 -> in_ready=0 on all channels and out_valid stays 0.
REQ-035 rst asserted asynchronously mid-stream while out_valid=1 -> out_valid=0 immediately; after release with in_valid=5'b10110, the first out_ch is 1.
